// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with its own storage, binary pointer control,
// registered occupancy count, threshold flags, a registered read port with a one-cycle
// valid strobe, and sticky overflow/underflow capture.
//
// Handshake semantics: ~wfull is the write-side ready and winc its valid; a word is
// taken on a rising edge only when winc=1 and wfull=0. ~rempty is the read-side ready
// and rinc its request; a read is taken only when rinc=1 and rempty=0, and the word
// appears on rdata with rvalid=1 exactly one edge later. Requests made while not ready
// are dropped (no state change) and recorded in the sticky error flags.
module sync_fifo_ctrl #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                winc,
   input  logic [DATASIZE-1:0] wdata,
   output logic                wfull,
   output logic                walmost_full,
   input  logic                rinc,
   output logic [DATASIZE-1:0] rdata,
   output logic                rvalid,
   output logic                rempty,
   output logic                ralmost_empty,
   output logic [ADDRSIZE:0]   count,
   output logic                overflow,
   output logic                underflow
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam logic [ADDRSIZE:0] DEPTH_C = (ADDRSIZE+1)'(DEPTH);
   localparam logic [ADDRSIZE:0] AF_C    = (ADDRSIZE+1)'(AF_LEVEL);
   localparam logic [ADDRSIZE:0] AE_C    = (ADDRSIZE+1)'(AE_LEVEL);

   // Storage is deliberately not reset; only the control state is.
   logic [DATASIZE-1:0] mem [DEPTH];

   // Pointers carry one extra MSB so a full lap is distinguishable from empty.
   logic [ADDRSIZE:0] wptr;
   logic [ADDRSIZE:0] rptr;

   logic wr_ok;
   logic rd_ok;

   // Flags decode from the registered count only, so they cannot glitch on inputs.
   always_comb begin
      wfull         = (count == DEPTH_C);
      rempty        = (count == '0);
      walmost_full  = (count >= AF_C);
      ralmost_empty = (count <= AE_C);
      wr_ok         = winc & ~wfull;
      rd_ok         = rinc & ~rempty;
   end

   // Memory write port; a reset cycle blocks the write along with everything else.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wptr[ADDRSIZE-1:0]] <= wdata;
      end
   end

   // Pointer and occupancy update; a simultaneous accepted read and write leave count alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_ok) rptr <= rptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered read port: rdata holds its last word between reads, rvalid pulses once per read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd_ok;
         if (rd_ok) begin
            rdata <= mem[rptr[ADDRSIZE-1:0]];
         end
      end
   end

   // Sticky error capture; only reset clears these.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (winc && wfull)  overflow  <= 1'b1;
         if (rinc && rempty) underflow <= 1'b1;
      end
   end

endmodule
